// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared types and constants for the RV32M multiply/divide unit.
//            muldiv_op_t  - M-extension funct3 encodings
//            muldiv_state_t - iterative unit FSM states
//            DIV_ZERO_Q / INT_MIN - special divide results
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_t;

  localparam logic [XLEN-1:0] DIV_ZERO_Q = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN    = {1'b1, {(XLEN-1){1'b0}}};

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_step
// Purpose  : One combinational radix-2 iteration shared by multiply and divide.
//            Multiply: {hi,lo} is the accumulator, lo holds the remaining
//              multiplier bits, operand is the multiplicand (shift-add, LSB first).
//            Divide:   hi is the partial remainder, lo shifts the dividend out
//              and the quotient in, operand is the divisor (restoring).
// Ports    : is_div   in  1   select divide step
//            hi, lo   in  W   current working registers
//            operand  in  W   multiplicand / divisor magnitude
//            hi_next, lo_next out W  working registers after this step
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  is_div,
  input  logic [DATA_WIDTH-1:0] hi,
  input  logic [DATA_WIDTH-1:0] lo,
  input  logic [DATA_WIDTH-1:0] operand,
  output logic [DATA_WIDTH-1:0] hi_next,
  output logic [DATA_WIDTH-1:0] lo_next
);

  logic [DATA_WIDTH:0] trial;
  logic [DATA_WIDTH:0] diff;
  logic [DATA_WIDTH:0] sum;

  always_comb begin
    trial   = {hi, lo[DATA_WIDTH-1]};
    diff    = trial - {1'b0, operand};
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
    hi_next = hi;
    lo_next = lo;
    if (is_div) begin
      // trial < 2*divisor, so the top bit of diff is a clean borrow flag
      if (!diff[DATA_WIDTH]) begin
        hi_next = diff[DATA_WIDTH-1:0];
        lo_next = {lo[DATA_WIDTH-2:0], 1'b1};
      end else begin
        hi_next = trial[DATA_WIDTH-1:0];
        lo_next = {lo[DATA_WIDTH-2:0], 1'b0};
      end
    end else begin
      // carry out of the add becomes the new accumulator MSB after the shift
      {hi_next, lo_next} = {sum, lo[DATA_WIDTH-1:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv
// Purpose  : Iterative RV32M multiply/divide unit for the execute stage.
//            Works on operand magnitudes for DATA_WIDTH cycles, then applies
//            the sign fix-up. Divide-by-zero and signed overflow bypass the
//            iteration and complete on the next cycle.
// Ports    : clk, rst      clock / async active-high reset
//            start         execute-stage M-op, held while stalled
//            flush         execute-stage flush, abandons any operation
//            op            funct3 of the M-op
//            srcA, srcB    forwarded rs1 / rs2
//            stall         hold F/D/E, bubble M (combinational)
//            done          one-cycle result-valid strobe
//            result        registered result, held until next completion
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  flush,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] srcA,
  input  logic [DATA_WIDTH-1:0] srcB,
  output logic                  stall,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam logic [DATA_WIDTH-1:0] C_DIV_ZERO_Q = DATA_WIDTH'(DIV_ZERO_Q);
  localparam logic [DATA_WIDTH-1:0] C_INT_MIN    = DATA_WIDTH'(INT_MIN);
  localparam logic [CNT_WIDTH-1:0]  C_LAST_STEP  = CNT_WIDTH'(DATA_WIDTH - 1);

  muldiv_state_t         state, state_nxt;
  muldiv_op_t            op_q, op_nxt, op_in;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_nxt;
  logic [DATA_WIDTH-1:0] hi_q, hi_nxt, lo_q, lo_nxt, opnd_q, opnd_nxt;
  logic [DATA_WIDTH-1:0] result_q, result_nxt;
  logic                  neg_q, neg_nxt;    // product / quotient sign
  logic                  rneg_q, rneg_nxt;  // remainder sign (dividend)

  logic                    a_signed, b_signed, a_neg, b_neg, is_div_in;
  logic [DATA_WIDTH-1:0]   a_mag, b_mag, step_hi, step_lo, quo_fix, rem_fix;
  logic [2*DATA_WIDTH-1:0] prod, prod_fix;

  muldiv_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .is_div  (op_q[2]),
    .hi      (hi_q),
    .lo      (lo_q),
    .operand (opnd_q),
    .hi_next (step_hi),
    .lo_next (step_lo)
  );

  always_comb begin
    op_in     = muldiv_op_t'(op);
    is_div_in = op_in[2];
    a_signed  = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                (op_in == OP_DIV)  || (op_in == OP_REM);
    b_signed  = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    a_neg     = a_signed & srcA[DATA_WIDTH-1];
    b_neg     = b_signed & srcB[DATA_WIDTH-1];
    a_mag     = a_neg ? -srcA : srcA;
    b_mag     = b_neg ? -srcB : srcB;

    prod      = {step_hi, step_lo};
    prod_fix  = neg_q  ? -prod    : prod;
    quo_fix   = neg_q  ? -step_lo : step_lo;
    rem_fix   = rneg_q ? -step_hi : step_hi;

    state_nxt  = state;
    op_nxt     = op_q;
    cnt_nxt    = cnt_q;
    hi_nxt     = hi_q;
    lo_nxt     = lo_q;
    opnd_nxt   = opnd_q;
    neg_nxt    = neg_q;
    rneg_nxt   = rneg_q;
    result_nxt = result_q;

    unique case (state)
      ST_IDLE: begin
        if (start && !flush) begin
          op_nxt   = op_in;
          cnt_nxt  = '0;
          neg_nxt  = a_neg ^ b_neg;
          rneg_nxt = a_neg;
          hi_nxt   = '0;
          lo_nxt   = is_div_in ? a_mag : b_mag;
          opnd_nxt = is_div_in ? b_mag : a_mag;
          state_nxt = ST_CALC;
          if (is_div_in && (srcB == '0)) begin
            result_nxt = op_in[1] ? srcA : C_DIV_ZERO_Q;
            state_nxt  = ST_DONE;
          end else if (((op_in == OP_DIV) || (op_in == OP_REM)) &&
                       (srcA == C_INT_MIN) && (srcB == '1)) begin
            result_nxt = op_in[1] ? '0 : C_INT_MIN;
            state_nxt  = ST_DONE;
          end
        end
      end
      ST_CALC: begin
        hi_nxt  = step_hi;
        lo_nxt  = step_lo;
        cnt_nxt = cnt_q + 1'b1;
        if (cnt_q == C_LAST_STEP) begin
          state_nxt = ST_DONE;
          unique case (op_q)
            OP_MUL:                       result_nxt = prod_fix[DATA_WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result_nxt = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
            OP_DIV, OP_DIVU:              result_nxt = quo_fix;
            default:                      result_nxt = rem_fix;
          endcase
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // flush overrides everything: drop the operation and keep the old result
    if (flush) begin
      state_nxt  = ST_IDLE;
      result_nxt = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_q     <= OP_MUL;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state    <= state_nxt;
      op_q     <= op_nxt;
      cnt_q    <= cnt_nxt;
      hi_q     <= hi_nxt;
      lo_q     <= lo_nxt;
      opnd_q   <= opnd_nxt;
      neg_q    <= neg_nxt;
      rneg_q   <= rneg_nxt;
      result_q <= result_nxt;
    end
  end

  assign done   = (state == ST_DONE) && !flush;
  assign stall  = start && (state != ST_DONE) && !flush;
  assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_muldiv
// Purpose  : Directed self-checking bench for ex_muldiv with hand-computed
//            expected results, latencies and stall lengths.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv;

  logic        clk;
  logic        rst;
  logic        start;
  logic        flush;
  logic [2:0]  op;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int total;
  int bad;

  ex_muldiv #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .flush  (flush),
    .op     (op),
    .srcA   (srcA),
    .srcB   (srcB),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Issue one M-op at the next falling edge and follow it to its done strobe.
  // lat counts cycles from the issue cycle to the done cycle; stalls counts
  // cycles with stall high up to (not including) the done cycle.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit release_start, output int lat, output int stalls,
                       output logic [31:0] res);
    bit got;
    got    = 0;
    lat    = -1;
    stalls = 0;
    res    = 'x;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    srcA  = a;
    srcB  = b;
    for (int i = 0; i < 80; i++) begin
      #1;
      if (done) begin
        got = 1;
        lat = i;
        res = result;
        check("stall_low_on_done", {31'd0, stall}, 32'd0);
        break;
      end
      if (stall) stalls++;
      @(negedge clk);
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
    if (release_start) begin
      start = 1'b0;
      @(negedge clk);
      #1;
      check("done_one_cycle", {31'd0, done}, 32'd0);
    end
  endtask

  int          lat, stalls;
  logic [31:0] res;
  bit          saw_done;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op    = 3'b000;
    srcA  = '0;
    srcB  = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_done",   {31'd0, done},  32'd0);
    check("reset_result", result,         32'd0);
    check("reset_stall",  {31'd0, stall}, 32'd0);
    rst = 1'b0;

    // MUL 7 * -3
    do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 1, lat, stalls, res);
    check("mul_res", res, 32'hFFFF_FFEB);
    check("mul_lat", 32'(lat), 32'd33);
    check("mul_stall", 32'(stalls), 32'd33);

    do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, lat, stalls, res);
    check("mulhu_res", res, 32'hFFFF_FFFE);
    do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, lat, stalls, res);
    check("mulh_res", res, 32'h0000_0000);
    do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, lat, stalls, res);
    check("mulhsu_res", res, 32'hFFFF_FFFF);

    do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 1, lat, stalls, res);
    check("div_res", res, 32'hFFFF_FFFD);
    check("div_lat", 32'(lat), 32'd33);
    do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 1, lat, stalls, res);
    check("rem_res", res, 32'hFFFF_FFFF);
    do_op(3'b101, 32'd100, 32'd7, 1, lat, stalls, res);
    check("divu_res", res, 32'd14);
    do_op(3'b111, 32'd100, 32'd7, 1, lat, stalls, res);
    check("remu_res", res, 32'd2);

    // fast paths
    do_op(3'b101, 32'd5, 32'd0, 1, lat, stalls, res);
    check("divu0_res", res, 32'hFFFF_FFFF);
    check("divu0_lat", 32'(lat), 32'd1);
    check("divu0_stall", 32'(stalls), 32'd1);
    do_op(3'b110, 32'd5, 32'd0, 1, lat, stalls, res);
    check("rem0_res", res, 32'd5);
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1, lat, stalls, res);
    check("divovf_res", res, 32'h8000_0000);
    check("divovf_lat", 32'(lat), 32'd1);
    do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1, lat, stalls, res);
    check("removf_res", res, 32'd0);

    // back-to-back: start stays high through the DONE cycle
    do_op(3'b000, 32'd3, 32'd4, 0, lat, stalls, res);
    check("b2b_mul_res", res, 32'd12);
    do_op(3'b100, 32'd12, 32'd5, 1, lat, stalls, res);
    check("b2b_div_res", res, 32'd2);
    check("b2b_div_lat", 32'(lat), 32'd33);
    check("b2b_div_stall", 32'(stalls), 32'd33);

    // flush at t+10: no done, result keeps 2
    @(negedge clk);
    start = 1'b1;
    op    = 3'b101;
    srcA  = 32'd100;
    srcB  = 32'd7;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_stall", {31'd0, stall}, 32'd0);
    check("flush_done",  {31'd0, done},  32'd0);
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (done) saw_done = 1;
      @(negedge clk);
    end
    check("flush_no_done", {31'd0, saw_done}, 32'd0);
    check("flush_result_kept", result, 32'd2);
    // unit must be idle again: a fresh op takes the full normal latency
    do_op(3'b111, 32'd100, 32'd7, 1, lat, stalls, res);
    check("post_flush_res", res, 32'd2);
    check("post_flush_lat", 32'(lat), 32'd33);

    // async reset at t+5
    do_op(3'b000, 32'd6, 32'd7, 1, lat, stalls, res);
    check("pre_rst_res", res, 32'd42);
    @(negedge clk);
    start = 1'b1;
    op    = 3'b000;
    srcA  = 32'd9;
    srcB  = 32'd9;
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_done",   {31'd0, done}, 32'd0);
    check("arst_result", result,        32'd0);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (done) saw_done = 1;
      @(negedge clk);
    end
    check("arst_no_done", {31'd0, saw_done}, 32'd0);
    do_op(3'b100, 32'hFFFF_FF9C, 32'd7, 1, lat, stalls, res);
    check("post_rst_div", res, 32'hFFFF_FFF2);
    check("post_rst_lat", 32'(lat), 32'd33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
